mio_in_filter: RTL and testbench

Per-pad input conditioning stage that sits directly downstream of the pad ring and consumes its `mio_in_o` vector. Each pad input is synchronised into the core clock domain, optionally glitch-filtered by a per-pad persistence counter, and edge-detected. Filtered levels and single-cycle rise/fall pulses feed the pinmux and the wakeup/interrupt logic.

---
 rtl/mio_in_filter_pkg.sv | 14 +
 rtl/mio_in_filter_chan.sv | 67 ++++++
 rtl/mio_in_filter.sv | 36 +++
 tb/tb_mio_in_filter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_in_filter_pkg.sv
// Shared constants and configuration type for the MIO pad input filter.
// Also used by the padctrl register mapping.
package mio_in_filter_pkg;

  localparam int MioFiltNPads      = 32;
  localparam int MioFiltCntW       = 4;
  localparam int MioFiltSyncStages = 2;

  typedef struct packed {
    logic [MioFiltNPads-1:0] en;
    logic [MioFiltCntW-1:0]  thresh;
  } mio_filt_cfg_t;

endpackage

// File: rtl/mio_in_filter_chan.sv
// One pad: synchroniser, persistence filter on the stable level, and
// registered rise/fall pulses aligned with the level they describe.
module mio_in_filter_chan
  import mio_in_filter_pkg::*;
#(
  parameter int SyncStages = MioFiltSyncStages,
  parameter int CntW       = MioFiltCntW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pad_i,
  input  logic            en_i,
  input  logic [CntW-1:0] thresh_i,
  output logic            lvl_o,
  output logic            rise_o,
  output logic            fall_o
);

  logic [SyncStages-1:0] r_sync;
  logic                  r_stb;
  logic [CntW-1:0]       r_cnt;
  logic                  r_rise;
  logic                  r_fall;

  logic                  w_syn;
  logic                  w_stb_nxt;
  logic [CntW-1:0]       w_cnt_nxt;

  assign w_syn = r_sync[SyncStages-1];

  // The counter holds the number of prior differing cycles, so a commit
  // needs T+1 consecutive differing cycles and the counter never exceeds T.
  always_comb begin
    w_stb_nxt = r_stb;
    w_cnt_nxt = '0;
    if (!en_i) begin
      w_stb_nxt = w_syn;
    end else if (w_syn != r_stb) begin
      if (r_cnt >= thresh_i) begin
        w_stb_nxt = w_syn;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_stb  <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], pad_i};
      r_stb  <= w_stb_nxt;
      r_cnt  <= w_cnt_nxt;
      r_rise <= ~r_stb & w_stb_nxt;
      r_fall <= r_stb & ~w_stb_nxt;
    end
  end

  assign lvl_o  = r_stb;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/mio_in_filter.sv
// Per-pad input conditioning downstream of the pad ring: one independent
// filter channel per MIO pad, all sharing a single persistence threshold.
module mio_in_filter
  import mio_in_filter_pkg::*;
#(
  parameter int NPads      = MioFiltNPads,
  parameter int SyncStages = MioFiltSyncStages,
  parameter int CntW       = MioFiltCntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NPads-1:0] pad_in_i,
  input  logic [NPads-1:0] filt_en_i,
  input  logic [CntW-1:0]  filt_thresh_i,
  output logic [NPads-1:0] in_o,
  output logic [NPads-1:0] rise_o,
  output logic [NPads-1:0] fall_o
);

  for (genvar g = 0; g < NPads; g++) begin : g_chan
    mio_in_filter_chan #(
      .SyncStages(SyncStages),
      .CntW      (CntW)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_i   (pad_in_i[g]),
      .en_i    (filt_en_i[g]),
      .thresh_i(filt_thresh_i),
      .lvl_o   (in_o[g]),
      .rise_o  (rise_o[g]),
      .fall_o  (fall_o[g])
    );
  end

endmodule

// File: tb/tb_mio_in_filter.sv
// Bench for mio_in_filter: directed scenarios plus random toggling, with a
// run-length reference model feeding a scoreboard checked every cycle.
module tb_mio_in_filter;
  import mio_in_filter_pkg::*;

  localparam int NP = 32;
  localparam int SS = MioFiltSyncStages;
  localparam int CW = MioFiltCntW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [NP-1:0] pad_in_i;
  logic [NP-1:0] filt_en_i;
  logic [CW-1:0] filt_thresh_i;
  logic [NP-1:0] in_o;
  logic [NP-1:0] rise_o;
  logic [NP-1:0] fall_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mio_in_filter #(.NPads(NP), .SyncStages(SS), .CntW(CW)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pad_in_i     (pad_in_i),
    .filt_en_i    (filt_en_i),
    .filt_thresh_i(filt_thresh_i),
    .in_o         (in_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o)
  );

  typedef struct packed {
    logic [NP-1:0] lvl;
    logic [NP-1:0] rs;
    logic [NP-1:0] fl;
  } exp_t;

  exp_t          expq[$];
  logic [NP-1:0] dly[$];
  logic [NP-1:0] m_lvl;
  int            m_run[NP];

  // Reference: pad value seen SS edges later is the synchronised input; it
  // is accepted once it has differed from the level for T+1 cycles in a row.
  always @(posedge clk) begin
    exp_t          e;
    logic [NP-1:0] syn;
    logic [NP-1:0] nlvl;
    if (rst_i) begin
      dly.delete();
      repeat (SS) dly.push_back('0);
      m_lvl = '0;
      for (int k = 0; k < NP; k++) m_run[k] = 0;
      e = '0;
    end else begin
      syn  = dly[SS-1];
      nlvl = m_lvl;
      for (int k = 0; k < NP; k++) begin
        if (!filt_en_i[k]) begin
          nlvl[k]  = syn[k];
          m_run[k] = 0;
        end else if (syn[k] == m_lvl[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k]++;
          if (m_run[k] >= int'(filt_thresh_i) + 1) begin
            nlvl[k]  = syn[k];
            m_run[k] = 0;
          end
        end
      end
      e.lvl = nlvl;
      e.rs  = ~m_lvl & nlvl;
      e.fl  = m_lvl & ~nlvl;
      m_lvl = nlvl;
      void'(dly.pop_back());
      dly.push_front(pad_in_i);
    end
    expq.push_back(e);
  end

  logic          cnt_on = 1'b0;
  logic [NP-1:0] prev_in;
  int            n_trans[NP];
  int            n_pulse[NP];

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: no expected entry at time %0t", $time);
    end else begin
      e = expq.pop_front();
      tests++;
      if ({in_o, rise_o, fall_o} !== e) begin
        fails++;
        $display("FAIL sb_cmp t=%0t: in/rise/fall got %h/%h/%h want %h/%h/%h",
                 $time, in_o, rise_o, fall_o, e.lvl, e.rs, e.fl);
      end
    end
    tests++;
    if ((rise_o & fall_o) !== '0) begin
      fails++;
      $display("FAIL rise_and_fall t=%0t: overlap %h want 0", $time, rise_o & fall_o);
    end
    for (int k = 0; k < NP; k++) begin
      if (!cnt_on) begin
        n_trans[k] = 0;
        n_pulse[k] = 0;
      end else begin
        if (in_o[k] !== prev_in[k]) n_trans[k]++;
        n_pulse[k] += int'(rise_o[k]) + int'(fall_o[k]);
      end
    end
    prev_in = in_o;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    logic [NP-1:0] b3, b5, b0, b7, b9;
    b3 = '0; b3[3] = 1'b1;
    b5 = '0; b5[5] = 1'b1;
    b0 = '0; b0[0] = 1'b1;
    b7 = '0; b7[7] = 1'b1;
    b9 = '0; b9[9] = 1'b1;
    rst_i = 1'b1;
    pad_in_i = b3;
    filt_en_i = '0;
    filt_thresh_i = '0;
    step(3);
    chk("reset_in", in_o, '0);
    chk("reset_pulses", rise_o | fall_o, '0);

    // Reset release with pad 3 high, filter off.
    rst_i = 1'b0;
    for (int i = 0; i < SS; i++) begin
      step(1);
      chk("rel_in_low", in_o, '0);
    end
    step(1);
    chk("rel_in3", in_o, b3);
    chk("rel_rise3", rise_o, b3);
    step(1);
    chk("rel_in3_hold", in_o, b3);
    chk("rel_rise_once", rise_o, '0);

    // T=3: 3-cycle glitch rejected, 4-cycle pulse accepted.
    filt_en_i = '1;
    filt_thresh_i = 4'd3;
    pad_in_i = b3 | b5;
    step(3);
    pad_in_i = b3;
    for (int i = 0; i < SS + 6; i++) begin
      step(1);
      chk("glitch_in5", in_o & b5, '0);
    end
    pad_in_i = b3 | b5;
    step(4);
    pad_in_i = b3;
    step(SS - 1);
    chk("pulse4_pre", in_o & b5, '0);
    step(1);
    chk("pulse4_in5", in_o & b5, b5);
    chk("pulse4_rise5", rise_o & b5, b5);
    step(10);

    // T=15: commit after 16 differing cycles, counter saturates at T.
    filt_thresh_i = 4'd15;
    pad_in_i = b3 | b0;
    step(SS + 15);
    chk("t15_pre", in_o & b0, '0);
    step(1);
    chk("t15_in0", in_o & b0, b0);
    chk("t15_rise0", rise_o & b0, b0);

    // T lowered 10 -> 2 while pad 7 counts down from high.
    filt_thresh_i = 4'd10;
    pad_in_i = b3 | b0 | b7;
    step(SS + 12);
    chk("t10_in7", in_o & b7, b7);
    pad_in_i = b3 | b0;
    step(SS + 5);
    chk("tchg_pre", in_o & b7, b7);
    filt_thresh_i = 4'd2;
    step(1);
    chk("tchg_in7", in_o & b7, '0);
    chk("tchg_fall7", fall_o & b7, b7);

    // Enable dropped mid-count on pad 9.
    filt_thresh_i = 4'd10;
    pad_in_i = b3 | b0 | b9;
    step(SS + 3);
    chk("endrop_pre", in_o & b9, '0);
    filt_en_i[9] = 1'b0;
    step(1);
    chk("endrop_in9", in_o & b9, b9);
    chk("endrop_rise9", rise_o & b9, b9);

    // Reset mid-count clears everything without pulses.
    filt_en_i[9] = 1'b1;
    pad_in_i = b3 | b0;
    step(SS + 2);
    rst_i = 1'b1;
    step(1);
    chk("rstmid_in", in_o, '0);
    chk("rstmid_pulse", rise_o | fall_o, '0);
    rst_i = 1'b0;
    step(1);
    chk("rstmid_after", in_o | rise_o | fall_o, '0);

    // Random toggling on all pads.
    step(SS + 20);
    cnt_on = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      pad_in_i = pad_in_i ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 40) == 0) filt_thresh_i = CW'($urandom_range(0, 4));
      if ($urandom_range(0, 200) == 0) filt_thresh_i = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 100) == 0) filt_en_i = $urandom;
      step(1);
    end
    step(1);
    cnt_on = 1'b0;
    for (int k = 0; k < NP; k++) begin
      tests++;
      if (n_pulse[k] != n_trans[k]) begin
        fails++;
        $display("FAIL pulse_count pad%0d: pulses %0d want %0d", k, n_pulse[k], n_trans[k]);
      end
    end
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
